branch_ctrl: RTL and testbench
==============================

Name: branch_ctrl

Overview:
- Control-side partner of the fetch unit: drives its Start, BranchEn, ALU_flag and Target inputs.
- Consumes the 9-bit instruction read at the current PC and the ALU compare result.
- Holds the condition-flag register, decodes branch/compare/halt opcodes, builds sign-extended or table-based targets, and runs the per-program start/done handshake with the host bench.

Parameters:
- HALT_OPC, 9'h0FF, instruction encoding that ends the current program.
- NUM_PROGS, 3, number of programs in series; ProgNum wraps to 0 after NUM_PROGS-1.
- FAR_TABLE, 64'h0, eight packed 8-bit signed far-branch offsets; entry i = FAR_TABLE[8i+7:8i].

Ports:
- Clk  in  1  clock; all state changes on posedge.
- Reset  in  1  synchronous, active-low reset.
- Req  in  1  host request to run the next program; level-sensitive.
- Instr  in  9  instruction at current ProgCtr; combinational ROM output.
- CmpFlag  in  1  ALU compare result; valid while Instr is a compare.
- Start  out  1  fetch hold; 1 freezes ProgCtr.
- BranchEn  out  1  current instruction is a branch.
- ALU_flag  out  1  branch condition is true.
- Target  out  8  signed relative jump distance.
- Done  out  1  program finished; waiting for the host to drop Req.
- ProgNum  out  2  index of the current or next program.
- CycleCnt  out  16  RUN cycles of the current or last program.

Behaviour:
- Reset (Reset==0 at posedge) has priority over everything, mid-program included.
  - state=IDLE, flag=0, ProgNum=0, CycleCnt=0.
  - Outputs after reset: Start=1, Done=0, BranchEn=0, ALU_flag=0, Target=0.
- States and transitions (registered; only transitions listed, otherwise hold):
  - IDLE -> RUN when Req=1. On this edge flag and CycleCnt clear to 0.
  - RUN -> HALT when Instr==HALT_OPC.
  - HALT -> IDLE when Req=0. ProgNum increments, wrapping NUM_PROGS-1 -> 0.
  - Req held high in HALT keeps HALT; a new program cannot start without a Req low phase.
- Start (combinational) = (state!=RUN) | (state==RUN & Instr==HALT_OPC).
  - The PC therefore parks on the halt instruction and never increments past it.
- Done = (state==HALT).
- Decode is active only in RUN with Instr!=HALT_OPC. Otherwise BranchEn=0, ALU_flag=0, Target=0.
- Compare: Instr[8:6]=3'b110.
  - flag <= CmpFlag at the next posedge.
  - BranchEn=0.
- Branch: Instr[8:6]=3'b111, BranchEn=1. Mode is Instr[5:4]:
  - 00: ALU_flag=flag; Target=sext(Instr[3:0]).
  - 01: ALU_flag=~flag; Target=sext(Instr[3:0]).
  - 10: ALU_flag=1 (unconditional); Target=sext(Instr[3:0]).
  - 11: ALU_flag=flag; Target=FAR_TABLE entry Instr[2:0]; Instr[3] ignored.
- sext: 4-bit two's complement to 8 bits; range -8..+7.
- Branches read the registered flag. A compare followed immediately by a branch sees the new flag (one-cycle latency, no hazard).
- All other classes: BranchEn=0; flag holds.
- CycleCnt counts cycles in RUN, including the halt cycle.
  - Saturates at 16'hFFFF.
  - Holds through HALT and IDLE; clears only on IDLE->RUN or reset.
- Outputs are combinational from state/flag/Instr; there are no output registers. Latency from Instr change to branch outputs is 0 cycles.

Test Plan:
1. Reset low 2 cycles while Req=1 -> Start=1, Done=0, ProgNum=0, CycleCnt=0; with Reset high and Req=1, RUN is entered on the next edge and Start=0.
2. RUN, Instr=110_000000 with CmpFlag=1, then Instr=111_00_1101 -> BranchEn=1, ALU_flag=1, Target=-3 (8'hFD); repeat with CmpFlag=0 -> ALU_flag=0.
3. flag=0, Instr=111_01_0111 -> ALU_flag=1, Target=+7; Instr=111_10_1000 -> ALU_flag=1, Target=-8.
4. FAR_TABLE entry 5 = 8'hC0, flag=1, Instr=111_11_0101 -> Target=-64, ALU_flag=1.
5. Instr=HALT_OPC after 10 RUN cycles -> Start=1 that cycle; Done=1 next cycle; CycleCnt=10 and held. Req low -> IDLE, ProgNum=1. Repeat to ProgNum=2 -> next wraps to 0.
6. Reset low mid-RUN with flag=1, ProgNum=1 -> next cycle IDLE, flag=0, ProgNum=0, Start=1, BranchEn=0.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// Host/fetch-side signal bundle for branch_ctrl.
// master: the bench or host that supplies Req, Instr and CmpFlag.
// slave:  branch_ctrl, which drives the fetch controls and status.
interface branch_ctrl_if;
  logic        Req;
  logic [8:0]  Instr;
  logic        CmpFlag;
  logic        Start;
  logic        BranchEn;
  logic        ALU_flag;
  logic [7:0]  Target;
  logic        Done;
  logic [1:0]  ProgNum;
  logic [15:0] CycleCnt;

  modport master (
    output Req, Instr, CmpFlag,
    input  Start, BranchEn, ALU_flag, Target, Done, ProgNum, CycleCnt
  );

  modport slave (
    input  Req, Instr, CmpFlag,
    output Start, BranchEn, ALU_flag, Target, Done, ProgNum, CycleCnt
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch/compare/halt control for the fetch unit. Holds the condition
// flag, decodes the instruction at the current PC into branch controls,
// and sequences programs through an IDLE/RUN/HALT handshake with the host.
module branch_ctrl #(
  parameter logic [8:0]  HALT_OPC  = 9'h0FF,
  parameter int unsigned NUM_PROGS = 3,
  parameter logic [63:0] FAR_TABLE = 64'h0
) (
  input logic         Clk,
  input logic         Reset,
  branch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  localparam logic [1:0] LAST_PROG = 2'(NUM_PROGS - 1);

  state_e      state_q, state_d;
  logic        flag_q,  flag_d;
  logic [1:0]  prog_q,  prog_d;
  logic [15:0] cyc_q,   cyc_d;
  logic        active;

  // Next-state: program sequencing, compare-flag capture, RUN cycle count.
  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    prog_d  = prog_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      IDLE: begin
        if (bus.Req) begin
          state_d = RUN;
          flag_d  = 1'b0;
          cyc_d   = '0;
        end
      end
      RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 16'd1;
        if (bus.Instr == HALT_OPC) begin
          state_d = HALT;
        end else if (bus.Instr[8:6] == 3'b110) begin
          flag_d = bus.CmpFlag;
        end
      end
      HALT: begin
        if (!bus.Req) begin
          state_d = IDLE;
          prog_d  = (prog_q == LAST_PROG) ? 2'd0 : prog_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      flag_q  <= 1'b0;
      prog_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      prog_q  <= prog_d;
      cyc_q   <= cyc_d;
    end
  end

  // Combinational fetch controls; decode only while running a non-halt word.
  always_comb begin
    active       = (state_q == RUN) && (bus.Instr != HALT_OPC);
    bus.Start    = !active;
    bus.Done     = (state_q == HALT);
    bus.ProgNum  = prog_q;
    bus.CycleCnt = cyc_q;
    bus.BranchEn = 1'b0;
    bus.ALU_flag = 1'b0;
    bus.Target   = '0;
    if (active && (bus.Instr[8:6] == 3'b111)) begin
      bus.BranchEn = 1'b1;
      unique case (bus.Instr[5:4])
        2'b00: begin
          bus.ALU_flag = flag_q;
          bus.Target   = {{4{bus.Instr[3]}}, bus.Instr[3:0]};
        end
        2'b01: begin
          bus.ALU_flag = !flag_q;
          bus.Target   = {{4{bus.Instr[3]}}, bus.Instr[3:0]};
        end
        2'b10: begin
          bus.ALU_flag = 1'b1;
          bus.Target   = {{4{bus.Instr[3]}}, bus.Instr[3:0]};
        end
        default: begin
          // Far mode: Instr[3] is ignored, only three index bits select the entry.
          bus.ALU_flag = flag_q;
          bus.Target   = FAR_TABLE[{bus.Instr[2:0], 3'b000} +: 8];
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Randomized self-checking bench for branch_ctrl against a behavioural model.
module tb_branch_ctrl;

  localparam logic [8:0]  HALT_V = 9'h0FF;
  localparam logic [63:0] FAR_V  = 64'h0123C0456789ABCD;

  logic Clk;
  logic Reset;
  branch_ctrl_if bus ();

  branch_ctrl #(
    .HALT_OPC (HALT_V),
    .NUM_PROGS(3),
    .FAR_TABLE(FAR_V)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  bit   m_run, m_halt;
  bit   m_flag;
  int   m_prog, m_cyc;
  logic [7:0] far_b [8];

  // Expected outputs packed as {Start,BranchEn,ALU_flag,Target,Done,ProgNum,CycleCnt}
  function automatic logic [29:0] exp_outs();
    logic st, be, af, dn;
    logic [7:0] tg;
    int off, t;
    st = !m_run || (bus.Instr == HALT_V);
    be = 0; af = 0; tg = 8'd0;
    if (m_run && bus.Instr != HALT_V && bus.Instr[8:6] == 3'd7) begin
      be  = 1;
      off = int'(bus.Instr[3:0]);
      t   = (off >= 8) ? off - 16 : off;
      case (bus.Instr[5:4])
        2'd0: af = m_flag;
        2'd1: af = !m_flag;
        2'd2: af = 1;
        default: begin
          af = m_flag;
          t  = int'(far_b[bus.Instr[2:0]]);
        end
      endcase
      tg = t[7:0];
    end
    dn = m_halt;
    return {st, be, af, tg, dn, 2'(m_prog), 16'(m_cyc)};
  endfunction

  function automatic logic [29:0] act_outs();
    return {bus.Start, bus.BranchEn, bus.ALU_flag, bus.Target, bus.Done,
            bus.ProgNum, bus.CycleCnt};
  endfunction

  // Advance one clock, updating the model with the inputs present at the edge.
  task automatic tick();
    @(posedge Clk);
    if (!Reset) begin
      m_run = 0; m_halt = 0; m_flag = 0; m_prog = 0; m_cyc = 0;
    end else if (m_run) begin
      if (m_cyc < 65535) m_cyc = m_cyc + 1;
      if (bus.Instr == HALT_V) begin
        m_run = 0; m_halt = 1;
      end else if (bus.Instr[8:6] == 3'd6) begin
        m_flag = bus.CmpFlag;
      end
    end else if (m_halt) begin
      if (!bus.Req) begin
        m_halt = 0;
        m_prog = (m_prog + 1) % 3;
      end
    end else if (bus.Req) begin
      m_run = 1; m_flag = 0; m_cyc = 0;
    end
    #1;
  endtask

  function automatic logic [8:0] rand_non_halt();
    logic [8:0] v;
    v = 9'($urandom);
    if (v == HALT_V) v = 9'h000;
    return v;
  endfunction

  task automatic test_reset();
    logic [29:0] e;
    bus.Req = 1; bus.Instr = 9'h000; bus.CmpFlag = 0; Reset = 0;
    tick(); tick();
    e = exp_outs();
    total++; if (bus.Start !== 1'b1) begin bad++; $display("FAIL reset_start act=%b exp=1", bus.Start); end
    total++; if (bus.Done !== 1'b0) begin bad++; $display("FAIL reset_done act=%b exp=0", bus.Done); end
    total++; if (bus.ProgNum !== 2'd0) begin bad++; $display("FAIL reset_prognum act=%0d exp=0", bus.ProgNum); end
    total++; if (bus.CycleCnt !== 16'd0) begin bad++; $display("FAIL reset_cyclecnt act=%0d exp=0", bus.CycleCnt); end
    total++; if (act_outs() !== e) begin bad++; $display("FAIL reset_all act=%h exp=%h", act_outs(), e); end
    Reset = 1;
    tick();
    total++; if (bus.Start !== 1'b0) begin bad++; $display("FAIL reset_to_run_start act=%b exp=0", bus.Start); end
  endtask

  task automatic test_compare_branch();
    logic [29:0] e;
    for (int r = 0; r < 2; r++) begin
      bus.Instr = 9'b110_000000; bus.CmpFlag = (r == 0); #1;
      e = exp_outs();
      total++; if (act_outs() !== e) begin bad++; $display("FAIL cmp_cycle act=%h exp=%h", act_outs(), e); end
      tick();
      bus.Instr = 9'b111_00_1101; bus.CmpFlag = 0; #1;
      e = exp_outs();
      total++; if (bus.BranchEn !== e[28]) begin bad++; $display("FAIL br_en act=%b exp=%b", bus.BranchEn, e[28]); end
      total++; if (bus.ALU_flag !== e[27]) begin bad++; $display("FAIL br_flag r=%0d act=%b exp=%b", r, bus.ALU_flag, e[27]); end
      total++; if (bus.Target !== e[26:19]) begin bad++; $display("FAIL br_target act=%h exp=%h", bus.Target, e[26:19]); end
      tick();
    end
  endtask

  task automatic test_modes();
    logic [29:0] e;
    logic [8:0] seq [3] = '{9'b110_000000, 9'b111_01_0111, 9'b111_10_1000};
    bus.CmpFlag = 0;
    foreach (seq[i]) begin
      bus.Instr = seq[i]; #1;
      e = exp_outs();
      total++; if (act_outs() !== e) begin bad++; $display("FAIL mode instr=%h act=%h exp=%h", seq[i], act_outs(), e); end
      tick();
    end
  endtask

  task automatic test_far();
    logic [29:0] e;
    logic [8:0] seq [4] = '{9'b110_000000, 9'b111_11_0101, 9'b111_11_1101, 9'b111_11_0010};
    foreach (seq[i]) begin
      bus.Instr = seq[i]; bus.CmpFlag = 1; #1;
      e = exp_outs();
      total++; if (act_outs() !== e) begin bad++; $display("FAIL far instr=%h act=%h exp=%h", seq[i], act_outs(), e); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [29:0] e;
    for (int i = 0; i < 400; i++) begin
      bus.Instr = rand_non_halt();
      if (($urandom & 3) != 0) bus.Instr[8] = 1'b1;
      if (bus.Instr == HALT_V) bus.Instr = 9'h1C0;
      bus.CmpFlag = 1'($urandom);
      bus.Req = 1'($urandom);
      #1;
      e = exp_outs();
      total++; if (act_outs() !== e) begin bad++; $display("FAIL random i=%0d instr=%h act=%h exp=%h", i, bus.Instr, act_outs(), e); end
      tick();
    end
  endtask

  task automatic test_halt_series();
    logic [29:0] e;
    for (int p = 0; p < 4; p++) begin
      bus.Req = 1;
      for (int k = 0; k < 9; k++) begin
        bus.Instr = rand_non_halt(); bus.CmpFlag = 1'($urandom); #1;
        e = exp_outs();
        total++; if (act_outs() !== e) begin bad++; $display("FAIL prog_body p=%0d act=%h exp=%h", p, act_outs(), e); end
        tick();
      end
      bus.Instr = HALT_V; #1;
      e = exp_outs();
      total++; if (act_outs() !== e || bus.Start !== 1'b1) begin bad++; $display("FAIL halt_cycle p=%0d act=%h exp=%h", p, act_outs(), e); end
      tick();
      e = exp_outs();
      total++; if (act_outs() !== e || bus.Done !== 1'b1) begin bad++; $display("FAIL halt_done p=%0d act=%h exp=%h", p, act_outs(), e); end
      if (p > 0) begin
        total++; if (bus.CycleCnt !== 16'd10) begin bad++; $display("FAIL halt_cyclecnt p=%0d act=%0d exp=10", p, bus.CycleCnt); end
      end
      bus.Instr = 9'b111_10_0001;
      tick(); tick();
      e = exp_outs();
      total++; if (act_outs() !== e) begin bad++; $display("FAIL halt_hold p=%0d act=%h exp=%h", p, act_outs(), e); end
      bus.Req = 0;
      tick();
      e = exp_outs();
      total++; if (act_outs() !== e) begin bad++; $display("FAIL to_idle p=%0d act=%h exp=%h", p, act_outs(), e); end
      total++; if (bus.ProgNum !== 2'((p + 1) % 3)) begin bad++; $display("FAIL prognum p=%0d act=%0d exp=%0d", p, bus.ProgNum, (p + 1) % 3); end
      bus.Req = 1; bus.Instr = 9'b111_10_0011; #1;
      e = exp_outs();
      total++; if (act_outs() !== e || bus.BranchEn !== 1'b0) begin bad++; $display("FAIL idle_decode p=%0d act=%h exp=%h", p, act_outs(), e); end
      tick();
      e = exp_outs();
      total++; if (act_outs() !== e || bus.CycleCnt !== 16'd0) begin bad++; $display("FAIL restart p=%0d act=%h exp=%h", p, act_outs(), e); end
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] e;
    bus.Instr = 9'b110_000000; bus.CmpFlag = 1; #1;
    tick();
    bus.Instr = 9'b111_00_0010; #1;
    e = exp_outs();
    total++; if (act_outs() !== e || m_prog != 1) begin bad++; $display("FAIL pre_reset act=%h exp=%h prog=%0d", act_outs(), e, m_prog); end
    Reset = 0;
    tick();
    Reset = 1; bus.Req = 0; #1;
    e = exp_outs();
    total++; if (act_outs() !== e) begin bad++; $display("FAIL mid_reset act=%h exp=%h", act_outs(), e); end
    total++; if (bus.Start !== 1'b1 || bus.BranchEn !== 1'b0 || bus.ProgNum !== 2'd0) begin
      bad++; $display("FAIL mid_reset_fields act=%b%b%0d exp=100", bus.Start, bus.BranchEn, bus.ProgNum); end
    bus.Req = 1;
    tick();
    bus.Instr = 9'b111_00_0000; #1;
    e = exp_outs();
    total++; if (act_outs() !== e || bus.ALU_flag !== 1'b0) begin bad++; $display("FAIL post_reset_flag act=%h exp=%h", act_outs(), e); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) far_b[i] = FAR_V[8*i +: 8];
    Reset = 0; bus.Req = 0; bus.Instr = '0; bus.CmpFlag = 0;
    m_run = 0; m_halt = 0; m_flag = 0; m_prog = 0; m_cyc = 0;
    @(negedge Clk);
    test_reset();
    test_compare_branch();
    test_modes();
    test_far();
    test_random();
    test_halt_series();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
